// File: rtl/exec_pkg.sv
// Shared constants and enums for the execute stage.
package exec_pkg;

    localparam int unsigned W  = 8;
    localparam int unsigned RA = 3;
    localparam int unsigned CW = 3;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_AND = 4'd2,
        OP_OR  = 4'd3,
        OP_XOR = 4'd4,
        OP_SLL = 4'd5,
        OP_SRL = 4'd6,
        OP_MUL = 4'd7,
        OP_MOV = 4'd8
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/exec_unit_if.sv
// Request/writeback bundle between the register file side and the execute stage.
interface exec_unit_if;
    import exec_pkg::*;

    logic          start;
    logic [3:0]    op;
    logic [RA-1:0] rd_idx;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          busy;
    logic          wb_en;
    logic [RA-1:0] wb_rd;
    logic [W-1:0]  wb_data;
    logic          done;
    logic          illegal;
    logic          flag_z;
    logic          flag_c;

    modport slave (
        input  start, op, rd_idx, a, b,
        output busy, wb_en, wb_rd, wb_data, done, illegal, flag_z, flag_c
    );

    modport master (
        output start, op, rd_idx, a, b,
        input  busy, wb_en, wb_rd, wb_data, done, illegal, flag_z, flag_c
    );
endinterface

// File: rtl/exec_unit_mul_iter.sv
// Iterative shift-add multiplier, one partial product per step; built only with EXEC_MUL_EN.
module mul_iter
    import exec_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    input  logic           load_i,
    input  logic           step_i,
    input  logic [W-1:0]   a_i,
    input  logic [W-1:0]   b_i,
    output logic [2*W-1:0] prod_nxt_c,
    output logic           count_done_c
);

    logic [W-1:0]   mcand_q;
    logic [2*W-1:0] prod_q;
    logic [CW-1:0]  cnt_q;
    logic [W:0]     sum;

    // Upper half accumulates the multiplicand when the current multiplier bit is set, then shifts right.
    always_comb begin
        sum          = {1'b0, prod_q[2*W-1:W]} + (prod_q[0] ? {1'b0, mcand_q} : (W+1)'(0));
        prod_nxt_c   = {sum, prod_q[W-1:1]};
        count_done_c = (cnt_q == CW'(W - 1));
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            mcand_q <= '0;
            prod_q  <= '0;
            cnt_q   <= '0;
        end else if (load_i) begin
            mcand_q <= a_i;
            prod_q  <= {W'(0), b_i};
            cnt_q   <= '0;
        end else if (step_i) begin
            prod_q  <= prod_nxt_c;
            cnt_q   <= cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/exec_unit.sv
// Execute stage: single-cycle ALU ops, iterative shifts, optional iterative MUL (EXEC_MUL_EN).
module exec_unit
    import exec_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    exec_unit_if.slave bus
);

    state_e        state_q, state_d;
    logic          busy_q, busy_d;
    logic          wb_en_q, wb_en_d;
    logic          done_q, done_d;
    logic          illegal_q, illegal_d;
    logic          flag_z_q, flag_z_d;
    logic          flag_c_q, flag_c_d;
    logic [RA-1:0] wb_rd_q, wb_rd_d;
    logic [W-1:0]  wb_data_q, wb_data_d;
    logic [3:0]    op_q, op_d;
    logic [W-1:0]  sh_q, sh_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          fin;
    logic [W-1:0]  res;
    logic          cy;
    logic [W:0]    sum9;
    logic [W-1:0]  shnxt;
    logic          shout;

`ifdef EXEC_MUL_EN
    logic           mul_load, mul_step, mul_done;
    logic [2*W-1:0] mul_prod;

    mul_iter u_mul (
        .clk          (clk),
        .reset        (reset),
        .load_i       (mul_load),
        .step_i       (mul_step),
        .a_i          (bus.a),
        .b_i          (bus.b),
        .prod_nxt_c   (mul_prod),
        .count_done_c (mul_done)
    );
`endif

    always_comb begin
        state_d   = state_q;
        busy_d    = 1'b0;
        wb_en_d   = 1'b0;
        done_d    = 1'b0;
        illegal_d = 1'b0;
        flag_z_d  = flag_z_q;
        flag_c_d  = flag_c_q;
        wb_rd_d   = wb_rd_q;
        wb_data_d = wb_data_q;
        op_d      = op_q;
        sh_d      = sh_q;
        cnt_d     = cnt_q;
        fin       = 1'b0;
        res       = W'(0);
        cy        = 1'b0;
        sum9      = (W+1)'(0);
        shnxt     = sh_q;
        shout     = 1'b0;
`ifdef EXEC_MUL_EN
        mul_load  = 1'b0;
        mul_step  = 1'b0;
`endif
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (bus.start) begin
                    op_d    = bus.op;
                    wb_rd_d = bus.rd_idx;
                    case (bus.op)
                        OP_ADD: begin
                            sum9 = {1'b0, bus.a} + {1'b0, bus.b};
                            res  = sum9[W-1:0];
                            cy   = sum9[W];
                            fin  = 1'b1;
                        end
                        OP_SUB: begin
                            sum9 = {1'b0, bus.a} - {1'b0, bus.b};
                            res  = sum9[W-1:0];
                            cy   = sum9[W];
                            fin  = 1'b1;
                        end
                        OP_AND: begin res = bus.a & bus.b; fin = 1'b1; end
                        OP_OR:  begin res = bus.a | bus.b; fin = 1'b1; end
                        OP_XOR: begin res = bus.a ^ bus.b; fin = 1'b1; end
                        OP_MOV: begin res = bus.b;         fin = 1'b1; end
                        OP_SLL, OP_SRL: begin
                            if (bus.b[CW-1:0] == CW'(0)) begin
                                res = bus.a;
                                fin = 1'b1;
                            end else begin
                                sh_d    = bus.a;
                                cnt_d   = bus.b[CW-1:0];
                                busy_d  = 1'b1;
                                state_d = RUN;
                            end
                        end
`ifdef EXEC_MUL_EN
                        OP_MUL: begin
                            mul_load = 1'b1;
                            busy_d   = 1'b1;
                            state_d  = RUN;
                        end
`else
                        OP_MUL: begin
                            state_d   = DONE;
                            done_d    = 1'b1;
                            illegal_d = 1'b1;
                        end
`endif
                        default: begin
                            state_d   = DONE;
                            done_d    = 1'b1;
                            illegal_d = 1'b1;
                        end
                    endcase
                end
            end
            RUN: begin
                busy_d = 1'b1;
`ifdef EXEC_MUL_EN
                if (op_q == OP_MUL) begin
                    mul_step = 1'b1;
                    if (mul_done) begin
                        res = mul_prod[W-1:0];
                        cy  = |mul_prod[2*W-1:W];
                        fin = 1'b1;
                    end
                end else
`endif
                begin
                    // One bit per cycle, zero-fill; carry keeps the last bit shifted out.
                    if (op_q == OP_SLL) begin
                        shout = sh_q[W-1];
                        shnxt = {sh_q[W-2:0], 1'b0};
                    end else begin
                        shout = sh_q[0];
                        shnxt = {1'b0, sh_q[W-1:1]};
                    end
                    sh_d  = shnxt;
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        res = shnxt;
                        cy  = shout;
                        fin = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (fin) begin
            state_d   = DONE;
            busy_d    = 1'b0;
            done_d    = 1'b1;
            wb_en_d   = 1'b1;
            wb_data_d = res;
            flag_z_d  = (res == W'(0));
            flag_c_d  = cy;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            wb_en_q   <= 1'b0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            flag_z_q  <= 1'b0;
            flag_c_q  <= 1'b0;
            wb_rd_q   <= '0;
            wb_data_q <= '0;
            op_q      <= '0;
            sh_q      <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            wb_en_q   <= wb_en_d;
            done_q    <= done_d;
            illegal_q <= illegal_d;
            flag_z_q  <= flag_z_d;
            flag_c_q  <= flag_c_d;
            wb_rd_q   <= wb_rd_d;
            wb_data_q <= wb_data_d;
            op_q      <= op_d;
            sh_q      <= sh_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.busy    = busy_q;
    assign bus.wb_en   = wb_en_q;
    assign bus.done    = done_q;
    assign bus.illegal = illegal_q;
    assign bus.flag_z  = flag_z_q;
    assign bus.flag_c  = flag_c_q;
    assign bus.wb_rd   = wb_rd_q;
    assign bus.wb_data = wb_data_q;

endmodule

// File: doc/exec_unit.md
Name: exec_unit

Overview:
- Execute stage directly downstream of the 8-entry, 8-bit register file.
- Takes the two read operands (`a` from `out_rd`, `b` from `out_rs`) plus an opcode, and computes the result.
- Single-cycle ops take one cycle; shifts and multiply are iterative multi-cycle ops.
- Drives the register file write port (`reg_write`/`rd`/`data_in`) with a one-cycle writeback pulse and holds Z/C flags for the branch logic.

Parameters:
- W, 8, datapath width (the register file is 8-bit; only 8 is verified)
- RA, 3, register index width

Ports:
- clk  in  1  clock, all state updates on posedge
- reset  in  1  synchronous, active-low; reset=0 at a posedge clears all state
- start  in  1  request; sampled at a posedge only when busy=0
- op  in  4  opcode (encoding under Behaviour)
- rd_idx  in  RA  destination register index
- a  in  W  operand A (from register file out_rd)
- b  in  W  operand B (from register file out_rs)
- busy  out  1  iterative op in progress; start ignored
- wb_en  out  1  one-cycle writeback pulse, wired to reg_write
- wb_rd  out  RA  writeback index, wired to rd
- wb_data  out  W  writeback value, wired to data_in
- done  out  1  one-cycle completion pulse (legal or illegal op)
- illegal  out  1  one-cycle pulse coincident with done for an unsupported op
- flag_z  out  1  last result == 0
- flag_c  out  1  last carry/borrow/shift-out/overflow

Behaviour:
- Reset (reset=0 at posedge):
  - state←IDLE.
  - busy, wb_en, done, illegal, flag_z, flag_c, wb_rd, wb_data ← 0.
  - Any in-flight op is abandoned with no writeback.
- Opcodes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 MUL, 8 MOV (result=b).
  - 9–15 illegal.
- Capture: op, rd_idx, a, b are latched on the accepting edge. Input changes afterwards have no effect.
- FSM states: IDLE, RUN, DONE.
  - IDLE/DONE + start, single-cycle op (ADD..XOR, MOV, shift by 0, illegal) → DONE.
  - IDLE/DONE + start, shift by n=b[2:0]≠0 or MUL → RUN.
  - IDLE/DONE, no start → IDLE.
  - RUN → DONE when the iteration counter hits terminal, else stays in RUN.
- Outputs per state:
  - busy=1 only in RUN.
  - DONE lasts exactly one cycle, with done=1.
  - wb_en=1 in DONE for legal ops; wb_en=0 and illegal=1 in DONE for illegal ops.
- Back-to-back: start is accepted in the DONE cycle, giving one result every cycle for single-cycle ops.
- Latency (start accepted at edge T; wb_en high in the cycle after edge...):
  - single-cycle ops: T+1
  - SLL/SRL by n: T+n, for n=1..7; one bit per cycle, zero-fill
  - MUL: T+8; 8 shift-add iterations, result = low W bits of a*b
- Arithmetic: widths W+1 internally.
  - ADD: C = bit W of the sum.
  - SUB: result = a−b mod 2^W; C = borrow (a<b unsigned).
  - AND/OR/XOR/MOV: C = 0.
  - Shifts: C = last bit shifted out; n=0 gives C=0.
  - MUL: C = (high W bits of product ≠ 0).
- Flags:
  - Updated only on edges where wb_en is asserted; Z = (wb_data==0).
  - Held otherwise, including on illegal ops.
- start while busy=1: ignored, with no state change.
- Reset wins over start on the same edge.

Optional Feature:
- EXEC_MUL_EN defined:
  - MUL (op 7) implemented as above via the iterative multiplier.
- EXEC_MUL_EN undefined:
  - No multiplier logic is built.
  - op 7 is treated as illegal: DONE at T+1 with illegal=1, wb_en=0, flags held.

Decomposition:
- Package exec_pkg holds:
  - op_e enum (4-bit, values above)
  - state_e enum (IDLE, RUN, DONE)
  - W=8 and RA=3 constants
- Sub-module mul_iter:
  - shift-add multiplier with load/step/count_done
  - instantiated only under EXEC_MUL_EN
- Shifts stay inline in exec_unit, sharing the iteration counter.

Test Plan:
- ADD a=0xF0, b=0x20, rd_idx=3 → wb_en pulse at T+1, wb_rd=3, wb_data=0x10, C=1, Z=0; busy never asserted.
- SUB a=0x05, b=0x05, then SUB a=0x01, b=0x02 back-to-back (second start in the DONE cycle):
  - first → wb_data=0x00, Z=1, C=0
  - second → wb_data=0xFF, Z=0, C=1 on consecutive cycles
- SLL a=0x81, b=0x03 → busy for 3 cycles, wb_data=0x08, C=0; a start pulsed mid-RUN is ignored.
- MUL a=0x13, b=0x11 (EXEC_MUL_EN) → wb at T+8, wb_data=0x43, C=1.
- Without EXEC_MUL_EN, the same MUL → done=1, illegal=1, wb_en=0 at T+1.
- MUL started, reset=0 at T+4 → all outputs 0 next cycle, no wb_en ever.
- op=12 → illegal pulse, flags unchanged from the prior op.
